phase_timing_gen: RTL and testbench

PHASE_TIMING_GEN -- requirements
Module: phase_timing_gen

---
 rtl/phase_timing_gen.sv | 110 +++++++++++
 tb/tb_phase_timing_gen.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/phase_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : phase_timing_gen
// Purpose  : Multi-phase machine-cycle timing generator. IDLE/RUN FSM that
//            steps a phase index through 0..PHASES-1, flags the second part
//            of each cycle, pulses on cycle completion and counts cycles.
// Revision : 1.0 - initial release
// ============================================================================
module phase_timing_gen #(
    parameter int PHASES     = 4,
    parameter int STEP_START = 2,
    parameter int CNT_W      = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                en,
    input  logic                                go,
    input  logic                                mode,
    input  logic                                halt,
    input  logic                                clr,
    output logic [((PHASES > 1) ? $clog2(PHASES) : 1)-1:0] phase,
    output logic [PHASES-1:0]                   phase_strb,
    output logic                                step,
    output logic                                cycle_done,
    output logic                                busy,
    output logic [CNT_W-1:0]                    cyc_count
);

    localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1;

    localparam logic [PW-1:0] LAST_PHASE = PW'(PHASES - 1);
    localparam logic [PW-1:0] STEP_PHASE = PW'(STEP_START);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state logic: clr dominates; halt/mode only matter on the wrap edge
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = ST_IDLE;
            phase_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    phase_d = '0;
                    if (go) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (phase_q == LAST_PHASE) begin
                        // Last phase is always exactly one clock, en ignored
                        phase_d = '0;
                        done_d  = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (mode || halt) begin
                            state_d = ST_IDLE;
                        end
                    end else if (en) begin
                        phase_d = phase_q + PW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                end
            endcase
        end
    end

    // State registers with immediate (asynchronous) reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    // One-hot phase decode, valid in both IDLE and RUN
    genvar gi;
    generate
        for (gi = 0; gi < PHASES; gi++) begin : g_strb
            assign phase_strb[gi] = (phase_q == PW'(gi));
        end
    endgenerate

    assign phase      = phase_q;
    assign busy       = (state_q == ST_RUN);
    assign step       = (state_q == ST_RUN) && (phase_q >= STEP_PHASE);
    assign cycle_done = done_q;
    assign cyc_count  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_phase_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_timing_gen
// Purpose  : Directed self-checking bench for phase_timing_gen; three
//            instances (default, PHASES=5, CNT_W=2) share one stimulus set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phase_timing_gen;

    logic clk = 1'b0;
    logic rst_n, en, go, mode, halt, clr;

    logic [1:0] phase_a;
    logic [3:0] strb_a;
    logic       step_a, done_a, busy_a;
    logic [7:0] cnt_a;

    logic [2:0] phase_b;
    logic [4:0] strb_b;
    logic       step_b, done_b, busy_b;
    logic [7:0] cnt_b;

    logic [1:0] phase_c;
    logic [3:0] strb_c;
    logic       step_c, done_c, busy_c;
    logic [1:0] cnt_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    phase_timing_gen dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .go(go), .mode(mode), .halt(halt),
        .clr(clr), .phase(phase_a), .phase_strb(strb_a), .step(step_a),
        .cycle_done(done_a), .busy(busy_a), .cyc_count(cnt_a)
    );

    phase_timing_gen #(.PHASES(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .go(go), .mode(mode), .halt(halt),
        .clr(clr), .phase(phase_b), .phase_strb(strb_b), .step(step_b),
        .cycle_done(done_b), .busy(busy_b), .cyc_count(cnt_b)
    );

    phase_timing_gen #(.CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .go(go), .mode(mode), .halt(halt),
        .clr(clr), .phase(phase_c), .phase_strb(strb_c), .step(step_c),
        .cycle_done(done_c), .busy(busy_c), .cyc_count(cnt_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the whole observable state of the default instance
    task automatic chk_a(input string tag, input int ph, input int bsy, input int stp,
                         input int dn, input int cnt);
        chk({tag, ".phase"}, 32'(phase_a), 32'(ph));
        chk({tag, ".strb"},  32'(strb_a),  32'(1 << ph));
        chk({tag, ".busy"},  32'(busy_a),  32'(bsy));
        chk({tag, ".step"},  32'(step_a),  32'(stp));
        chk({tag, ".done"},  32'(done_a),  32'(dn));
        chk({tag, ".cnt"},   32'(cnt_a),   32'(cnt));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int busy_n, done_n;
        rst_n = 1'b0; en = 1'b0; go = 1'b0; mode = 1'b0; halt = 1'b0; clr = 1'b0;

        // Reset values before any clock edge
        #2;
        chk_a("rst", 0, 0, 0, 0, 0);
        chk("rst.strb_b", 32'(strb_b), 32'h1);
        tick();
        rst_n = 1'b1;

        // Stays idle after release, en ignored in IDLE
        en = 1'b1;
        tick();
        chk_a("idle", 0, 0, 0, 0, 0);

        // Free-run, default params: 0,1,2,3,0 with step in phases 2..3
        go = 1'b1;
        tick();
        go = 1'b0;
        chk_a("fr.p0", 0, 1, 0, 0, 0);
        tick(); chk_a("fr.p1", 1, 1, 0, 0, 0);
        go = 1'b1;   // go in RUN is ignored
        tick(); chk_a("fr.p2", 2, 1, 1, 0, 0);
        go = 1'b0;
        tick(); chk_a("fr.p3", 3, 1, 1, 0, 0);
        tick(); chk_a("fr.w1", 0, 1, 0, 1, 1);
        tick(); chk_a("fr.p1b", 1, 1, 0, 0, 1);
        repeat (3) tick();
        chk_a("fr.w2", 0, 1, 0, 1, 2);

        // en stalls phases 0..2; last phase wraps even with en=0
        do_reset();
        go = 1'b1; tick(); go = 1'b0;
        en = 1'b1; tick(); chk("en.1", 32'(phase_a), 32'd1);
        en = 1'b0; tick(); chk("en.hold1", 32'(phase_a), 32'd1);
        tick(); chk("en.hold2", 32'(phase_a), 32'd1);
        en = 1'b1; tick(); chk("en.2", 32'(phase_a), 32'd2);
        tick(); chk("en.3", 32'(phase_a), 32'd3);
        en = 1'b0; tick(); chk_a("en.wrap", 0, 1, 0, 1, 1);

        // halt at phase 1 ignored; halt at last phase ends after wrap
        en = 1'b1; tick(); chk("halt.p1", 32'(phase_a), 32'd1);
        halt = 1'b1; tick(); chk_a("halt.ign", 2, 1, 1, 0, 1);
        halt = 1'b0; tick(); chk("halt.p3", 32'(phase_a), 32'd3);
        halt = 1'b1; tick(); chk_a("halt.wrap", 0, 0, 0, 1, 2);
        halt = 1'b0; tick(); chk_a("halt.idle", 0, 0, 0, 0, 2);

        // clr on the wrap edge: IDLE, no pulse, count held
        go = 1'b1; tick(); go = 1'b0;
        repeat (3) tick();
        chk("clr.p3", 32'(phase_a), 32'd3);
        clr = 1'b1; tick(); clr = 1'b0;
        chk_a("clr.wrap", 0, 0, 0, 0, 2);
        // clr also beats go in IDLE
        clr = 1'b1; go = 1'b1; tick(); clr = 1'b0; go = 1'b0;
        chk_a("clr.go", 0, 0, 0, 0, 2);

        // Asynchronous reset mid-cycle at phase 2
        go = 1'b1; tick(); go = 1'b0;
        tick(); tick();
        chk("arst.pre", 32'(phase_a), 32'd2);
        rst_n = 1'b0;
        #1;
        chk_a("arst", 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;

        // PHASES=5 single-cycle: 5 busy clocks, one pulse, back to IDLE
        mode = 1'b1; en = 1'b1;
        go = 1'b1; tick(); go = 1'b0;
        busy_n = 0; done_n = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy_b) busy_n++;
            tick();
            if (done_b) done_n++;
        end
        chk("p5.busy_clks", 32'(busy_n), 32'd5);
        chk("p5.done_n",    32'(done_n), 32'd1);
        chk("p5.phase",     32'(phase_b), 32'd0);
        chk("p5.busy",      32'(busy_b), 32'd0);
        chk("p5.strb",      32'(strb_b), 32'h1);
        chk("p5.cnt",       32'(cnt_b), 32'd1);

        // CNT_W=2 free-run: counts 1,2,3,0,1
        do_reset();
        mode = 1'b0;
        go = 1'b1; tick(); go = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (4) tick();
            chk($sformatf("c2.cnt%0d", i), 32'(cnt_c), 32'((i + 1) % 4));
            chk($sformatf("c2.done%0d", i), 32'(done_c), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
